// File: rtl/div_vl_pkg.sv
// Shared types and constants for the variable-latency signed divider.
package div_vl_pkg;

  localparam int W  = 32;
  localparam int CW = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_SIGN,
    ST_DONE
  } state_t;

  localparam logic [W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  // Two's-complement negate when neg is set; wraps to W bits.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  // Unsigned magnitude of a signed word; -2^31 maps to 2^31 exactly.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return cond_neg(x, x[W-1]);
  endfunction

endpackage

// File: rtl/div_vl_if.sv
// Request/result bundle between a divide requester and div_vl.
interface div_vl_if;
  import div_vl_pkg::*;

  logic [W-1:0] dvdnd;
  logic [W-1:0] dvsor;
  logic         start;
  logic [W-1:0] quot;
  logic [W-1:0] remd;
  logic         valid;
  logic         dv_zero;

  modport master (
    output dvdnd, dvsor, start,
    input  quot, remd, valid, dv_zero
  );

  modport slave (
    input  dvdnd, dvsor, start,
    output quot, remd, valid, dv_zero
  );

endinterface

// File: rtl/div_vl_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter, returns 32 for a zero input.
module lzc32
  import div_vl_pkg::*;
(
  input  logic [W-1:0]  din,
  output logic [CW-1:0] lz
);

  // seen[i] is set when any bit at or above position i is set.
  logic [W-1:0] seen;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_seen
      assign seen[gi] = |din[W-1:gi];
    end
  endgenerate

  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < W; i++) begin
      lz = lz - {5'd0, seen[i]};
    end
  end

endmodule

// File: rtl/div_vl.sv
// div_vl: variable-latency 32-bit signed restoring divider, truncating semantics.
// Define DIV_VL_EARLY_EXIT_EN to skip the leading zeros of the dividend magnitude.
module div_vl
  import div_vl_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  div_vl_if.slave   bus
);

  state_t        state_reg, state_next;
  logic [W-1:0]  a_mag_reg, a_mag_next;
  logic [W-1:0]  b_mag_reg, b_mag_next;
  logic          neg_a_reg, neg_a_next;
  logic          neg_b_reg, neg_b_next;
  logic          dz_reg, dz_next;
  logic [W-1:0]  dq_reg, dq_next;
  logic [W-1:0]  r_reg, r_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  quot_reg, quot_next;
  logic [W-1:0]  remd_reg, remd_next;
  logic          valid_reg, valid_next;
  logic          dv_zero_reg, dv_zero_next;

  logic [CW-1:0] lz;
  logic [CW-1:0] n_bits;
  logic [W:0]    t;
  logic          ge;

`ifdef DIV_VL_EARLY_EXIT_EN
  lzc32 u_lzc (
    .din (a_mag_reg),
    .lz  (lz)
  );
`else
  assign lz = '0;
`endif

  assign n_bits = 6'd32 - lz;

  // The remainder stays below the divisor magnitude, so 32 bits of r suffice.
  assign t  = {r_reg, dq_reg[W-1]};
  assign ge = (t >= {1'b0, b_mag_reg});

  always_comb begin
    state_next   = state_reg;
    a_mag_next   = a_mag_reg;
    b_mag_next   = b_mag_reg;
    neg_a_next   = neg_a_reg;
    neg_b_next   = neg_b_reg;
    dz_next      = dz_reg;
    dq_next      = dq_reg;
    r_next       = r_reg;
    cnt_next     = cnt_reg;
    quot_next    = quot_reg;
    remd_next    = remd_reg;
    valid_next   = 1'b0;
    dv_zero_next = dv_zero_reg;

    if (state_reg != ST_IDLE && !bus.start) begin
      // Request withdrawn: abandon whatever is in flight.
      state_next   = ST_IDLE;
      quot_next    = '0;
      remd_next    = '0;
      dv_zero_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            a_mag_next = mag(bus.dvdnd);
            b_mag_next = mag(bus.dvsor);
            neg_a_next = bus.dvdnd[W-1];
            neg_b_next = bus.dvsor[W-1];
            state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          dq_next  = a_mag_reg << lz;
          r_next   = '0;
          cnt_next = n_bits;
          dz_next  = (b_mag_reg == '0);
          if (b_mag_reg == '0 || n_bits == '0) begin
            state_next = ST_SIGN;
          end else begin
            state_next = ST_ITER;
          end
        end
        ST_ITER: begin
          dq_next  = {dq_reg[W-2:0], ge};
          r_next   = ge ? (t[W-1:0] - b_mag_reg) : t[W-1:0];
          cnt_next = cnt_reg - 6'd1;
          if (cnt_reg == 6'd1) begin
            state_next = ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (dz_reg) begin
            quot_next    = DZ_QUOT;
            remd_next    = cond_neg(a_mag_reg, neg_a_reg);
            dv_zero_next = 1'b1;
          end else begin
            quot_next    = cond_neg(dq_reg, neg_a_reg ^ neg_b_reg);
            remd_next    = cond_neg(r_reg, neg_a_reg);
            dv_zero_next = 1'b0;
          end
          valid_next = 1'b1;
          state_next = ST_DONE;
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      a_mag_reg   <= '0;
      b_mag_reg   <= '0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      dz_reg      <= 1'b0;
      dq_reg      <= '0;
      r_reg       <= '0;
      cnt_reg     <= '0;
      quot_reg    <= '0;
      remd_reg    <= '0;
      valid_reg   <= 1'b0;
      dv_zero_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_mag_reg   <= a_mag_next;
      b_mag_reg   <= b_mag_next;
      neg_a_reg   <= neg_a_next;
      neg_b_reg   <= neg_b_next;
      dz_reg      <= dz_next;
      dq_reg      <= dq_next;
      r_reg       <= r_next;
      cnt_reg     <= cnt_next;
      quot_reg    <= quot_next;
      remd_reg    <= remd_next;
      valid_reg   <= valid_next;
      dv_zero_reg <= dv_zero_next;
    end
  end

  assign bus.quot    = quot_reg;
  assign bus.remd    = remd_reg;
  assign bus.valid   = valid_reg;
  assign bus.dv_zero = dv_zero_reg;

endmodule

// File: tb/tb_div_vl.sv
// Directed scoreboard bench for div_vl; latency expectations follow DIV_VL_EARLY_EXIT_EN.
module tb_div_vl;
  import div_vl_pkg::*;

`ifdef DIV_VL_EARLY_EXIT_EN
  localparam int LAT_100   = 10;
  localparam int LAT_ZERO  = 3;
  localparam int LAT_7FFF  = 34;
`else
  localparam int LAT_100   = 35;
  localparam int LAT_ZERO  = 35;
  localparam int LAT_7FFF  = 35;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  div_vl_if bus();

  div_vl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat);
    exp_t e;
    int   edges;
    bit   seen;
    logic [31:0] q_obs, r_obs;
    logic        dz_obs;
    e = '{q: eq, r: er, dz: edz, lat: elat};
    sb.push_back(e);
    @(negedge clock);
    bus.dvdnd = a;
    bus.dvsor = b;
    bus.start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clock);
      edges++;
      #1;
      if (bus.valid) seen = 1'b1;
      // Scramble operands once captured; the result must not depend on them.
      if (edges == 1) begin
        bus.dvdnd = ~a;
        bus.dvsor = b + 32'd1;
      end
    end
    q_obs  = bus.quot;
    r_obs  = bus.remd;
    dz_obs = bus.dv_zero;
    e = sb.pop_front();
    check({name, ":latency"}, seen ? edges : 999, e.lat);
    check({name, ":quot"}, q_obs, e.q);
    check({name, ":remd"}, r_obs, e.r);
    check({name, ":dv_zero"}, {31'd0, dz_obs}, {31'd0, e.dz});
    @(posedge clock);
    #1;
    check({name, ":valid_one_cycle"}, {31'd0, bus.valid}, 32'd0);
    check({name, ":quot_held"}, bus.quot, e.q);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check({name, ":quot_cleared"}, bus.quot, 32'd0);
    check({name, ":remd_cleared"}, bus.remd, 32'd0);
    check({name, ":dz_cleared"}, {31'd0, bus.dv_zero}, 32'd0);
    $display("op %-10s %0d / %0d -> quot=%h remd=%h dz=%b latency=%0d",
             name, $signed(a), $signed(b), q_obs, r_obs, dz_obs, seen ? edges : -1);
  endtask

  task automatic run_abort(input string name, input bit use_reset);
    int pulses;
    @(negedge clock);
    bus.dvdnd = 32'h7FFF_FFFF;
    bus.dvsor = 32'd3;
    bus.start = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    if (use_reset) reset = 1'b0;
    else           bus.start = 1'b0;
    @(posedge clock);
    #1;
    check({name, ":quot_zero"}, bus.quot, 32'd0);
    check({name, ":remd_zero"}, bus.remd, 32'd0);
    @(negedge clock);
    reset     = 1'b1;
    bus.start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.valid) pulses++;
    end
    check({name, ":no_valid"}, pulses, 32'd0);
    $display("abort %-10s valid_pulses=%0d quot=%h remd=%h", name, pulses, bus.quot, bus.remd);
  endtask

  initial begin
    bus.dvdnd = 32'd100;
    bus.dvsor = 32'd7;
    bus.start = 1'b1;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset:quot", bus.quot, 32'd0);
    check("reset:remd", bus.remd, 32'd0);
    check("reset:valid", {31'd0, bus.valid}, 32'd0);
    check("reset:dv_zero", {31'd0, bus.dv_zero}, 32'd0);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    run_op("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_100);
    run_op("n100_p7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT_100);
    run_op("p100_n7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, LAT_100);
    run_op("n100_n7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, LAT_100);
    run_op("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35);
    run_op("div_zero", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 3);
    run_op("zero_div", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, LAT_ZERO);

    run_abort("start_drop", 1'b0);
    run_abort("reset_pull", 1'b1);

    run_op("max_3", 32'h7FFF_FFFF, 32'd3, 32'h2AAA_AAAA, 32'd1, 1'b0, LAT_7FFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_vl.md
# div_vl

Variable-latency 32-bit signed integer divider, the inverse companion to the variable-latency multiplier in the same arithmetic datapath. It uses the same level-held `start` / one-cycle `valid` handshake. The block skips leading zeros of the dividend magnitude, then runs one restoring shift/subtract step per remaining significant bit, so small dividends finish early. Results use truncating (round-toward-zero) semantics.

## Interface
- `W`, 32, operand/result width; only 32 is supported.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low (0 = reset), sampled on the rising edge of `clock`.
- `dvdnd` input 32: signed dividend (two's complement).
- `dvsor` input 32: signed divisor (two's complement).
- `start` input 1: level request, held high for the whole operation and until the result is consumed.
- `quot` output 32: signed quotient.
- `remd` output 32: signed remainder; its sign follows the dividend.
- `valid` output 1: one-cycle pulse when `quot`, `remd` and `dv_zero` are first valid.
- `dv_zero` output 1: divide-by-zero flag, qualified by `valid` and held with the result.

## Operation
- Reset (`reset`=0 at an edge): state IDLE; `quot`=0, `remd`=0, `valid`=0, `dv_zero`=0; all internal registers cleared. This applies in any state; mid-operation the operation is aborted.
- IDLE:
  - If `start`=1, register |dvdnd|, |dvsor| (33-bit, so -2^31 becomes 2^31 exactly), sign of the dividend, and sign of the divisor, then go to LOAD.
  - Operand changes after this edge are ignored.
- LOAD:
  - `lz` = leading-zero count of |dvdnd| (32 if zero).
  - `n` = 32-`lz`.
  - Dividend shift register `dq` = |dvdnd| << `lz`; partial remainder `r` (33 bits) = 0; iteration counter = `n`.
  - Divisor zero: go to SIGN with `dv_zero` pending.
  - `n`=0: go to SIGN.
  - Otherwise go to ITER.
- ITER, one step per cycle:
  - `t` = {`r`[31:0], `dq`[31]}.
  - `dq` = `dq` << 1.
  - If `t` >= |dvsor|: `r` = `t` - |dvsor| and `dq`[0] = 1; else `r` = `t` and `dq`[0] = 0.
  - Decrement the counter; after the `n`th step go to SIGN.
- SIGN: register the outputs, pulse `valid`=1, go to DONE.
  - Quotient magnitude is `dq`; remainder magnitude is `r`[31:0].
  - `quot` is negated iff the operand signs differ.
  - `remd` is negated iff the dividend is negative.
  - Arithmetic wraps to 32 bits, so -2^31 / -1 gives `quot`=0x80000000, `remd`=0 with no flag.
  - Divide-by-zero: `quot`=0xFFFFFFFF, `remd`=`dvdnd` as captured, `dv_zero`=1.
- DONE: `valid`=0; outputs held while `start`=1. When `start`=0: clear the outputs to 0 and go to IDLE.
- `start`=0 in any non-IDLE state: at the next edge go to IDLE, clear all outputs to 0, and do not pulse `valid`.
- A new operation needs `start` low for at least 1 cycle after DONE, because the request is level-based.

## Timing
- Edge E0 is the edge at which IDLE samples `start`=1. The outputs and `valid` update at edge E(`n`+2) and are visible in the following cycle.
- Latency counted in edges including E0:
  - `n`+3 in general; range 3..35.
  - 3 for a zero dividend.
  - 3 for a zero divisor.
- `valid` is high for exactly one cycle per operation.
- Reset at the same edge as a `start` rise: reset wins.
- `start` falling at the same edge as SIGN: the outputs are cleared and `valid` stays 0.
- No combinational path from the inputs to the outputs.

## Configuration
- `DIV_VL_EARLY_EXIT_EN` defined: leading-zero skip is active; latency is `n`+3 as above.
- `DIV_VL_EARLY_EXIT_EN` undefined:
  - LOAD forces `lz`=0 and `n`=32; the LZC sub-module is not instantiated.
  - Every nonzero-divisor operation, including a zero dividend, takes 35 edges.
  - Divide-by-zero still takes 3.
  - Numerical results are identical in both builds.

## Structure
- Shared package `div_vl_pkg` holds:
  - the width constant (32);
  - state encoding IDLE/LOAD/ITER/SIGN/DONE;
  - the divide-by-zero quotient constant 0xFFFFFFFF.
- Sub-module `lzc32`: combinational 32-bit leading-zero counter, 6-bit output, returns 32 for zero input; it is reusable by the multiplier.

## Test plan
- 100 / 7, early exit enabled -> `quot`=14, `remd`=2, `dv_zero`=0; `n`=7, so `valid` at edge 9 (latency 10 edges).
- Sign cases:
  - -100 / 7 -> `quot`=0xFFFFFFF2, `remd`=0xFFFFFFFE.
  - 100 / -7 -> `quot`=0xFFFFFFF2, `remd`=2.
  - -100 / -7 -> `quot`=14, `remd`=0xFFFFFFFE.
- 0x80000000 / 0xFFFFFFFF -> `quot`=0x80000000, `remd`=0, `dv_zero`=0, latency 35 edges.
- 5 / 0 -> `quot`=0xFFFFFFFF, `remd`=5, `dv_zero`=1, latency 3.
- 0 / 3 -> `quot`=0, `remd`=0:
  - latency 3 with `DIV_VL_EARLY_EXIT_EN`;
  - latency 35 without it.
- Abort and recovery on 0x7FFFFFFF / 3:
  - Drop `start` in the 4th ITER cycle -> the next edge gives IDLE with outputs 0 and no `valid`.
  - Repeat, pulling `reset` low mid-ITER -> the same result.
  - Clean rerun -> `quot`=0x2AAAAAAA, `remd`=1, one `valid` pulse.
